// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the systolic array: skews A columns onto the west edge and
// B rows onto the north edge, fills stalls with matched zero bubbles, then drains.
module systolic_skew_feeder #(
    parameter int N         = 4,
    parameter int WDATA     = 4,
    parameter int CFG_WIDTH = $clog2(N) + 1,
    parameter int KW        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic [CFG_WIDTH-1:0] row_cfg_in,
    input  logic [CFG_WIDTH-1:0] col_cfg_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WDATA-1:0]     in_a [1:N],
    input  logic [WDATA-1:0]     in_b [1:N],
    output logic [WDATA-1:0]     west_out [1:N],
    output logic [WDATA-1:0]     north_out [1:N],
    output logic                 busy,
    output logic                 done
);

    localparam int DW = $clog2(2 * N);
    localparam logic [DW-1:0]        DRAIN_LAST = DW'(2 * N - 2);
    localparam logic [CFG_WIDTH-1:0] CFG_MAX    = CFG_WIDTH'(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [KW-1:0]        beat_q, beat_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [CFG_WIDTH-1:0] row_cfg_q, row_cfg_d;
    logic [CFG_WIDTH-1:0] col_cfg_q, col_cfg_d;
    logic                 accept_s;
    logic [KW-1:0]        beat_inc_s;

    function automatic logic [CFG_WIDTH-1:0] clamp_cfg(input logic [CFG_WIDTH-1:0] v);
        return (v > CFG_MAX) ? CFG_MAX : v;
    endfunction

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign accept_s   = in_ready & in_valid;
    assign beat_inc_s = beat_q + KW'(1);

    // Job sequencing: latch config on start, count beats, time the drain.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        row_cfg_d = row_cfg_q;
        col_cfg_d = col_cfg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d       = k_len;
                    row_cfg_d = clamp_cfg(row_cfg_in);
                    col_cfg_d = clamp_cfg(col_cfg_in);
                    beat_d    = '0;
                    state_d   = (k_len == KW'(0)) ? S_DONE : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    beat_d = beat_inc_s;
                    if (beat_inc_s == k_q) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            beat_q    <= '0;
            drain_q   <= '0;
            row_cfg_q <= '0;
            col_cfg_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            beat_q    <= beat_d;
            drain_q   <= drain_d;
            row_cfg_q <= row_cfg_d;
            col_cfg_q <= col_cfg_d;
        end
    end

    // Lane r is an r-deep chain; non-accept cycles inject zeros so bubbles stay aligned.
    for (genvar r = 1; r <= N; r++) begin : g_lane
        logic [WDATA-1:0] west_q  [1:r];
        logic [WDATA-1:0] west_d  [1:r];
        logic [WDATA-1:0] north_q [1:r];
        logic [WDATA-1:0] north_d [1:r];

        // Next value of each chain stage.
        always_comb begin
            west_d[1]  = accept_s ? in_a[r] : '0;
            north_d[1] = accept_s ? in_b[r] : '0;
            for (int i = 2; i <= r; i++) begin
                west_d[i]  = west_q[i-1];
                north_d[i] = north_q[i-1];
            end
        end

        // Chain registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 1; i <= r; i++) begin
                    west_q[i]  <= '0;
                    north_q[i] <= '0;
                end
            end else begin
                west_q  <= west_d;
                north_q <= north_d;
            end
        end

        assign west_out[r]  = (CFG_WIDTH'(r) <= row_cfg_q) ? west_q[r]  : '0;
        assign north_out[r] = (CFG_WIDTH'(r) <= col_cfg_q) ? north_q[r] : '0;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder against a slot-history reference model.
module tb_systolic_skew_feeder;

    localparam int N         = 4;
    localparam int WDATA     = 4;
    localparam int CFG_WIDTH = $clog2(N) + 1;
    localparam int KW        = 8;

    logic                 clk = 1'b0;
    logic                 rst_n, start, in_valid, in_ready, busy, done;
    logic [KW-1:0]        k_len;
    logic [CFG_WIDTH-1:0] row_cfg_in, col_cfg_in;
    logic [WDATA-1:0]     in_a [1:N];
    logic [WDATA-1:0]     in_b [1:N];
    logic [WDATA-1:0]     west_out [1:N];
    logic [WDATA-1:0]     north_out [1:N];

    int checks = 0;
    int errors = 0;

    // Reference: job phase (0 idle, 1 load, 2 drain, 3 done) plus history of pushed slots.
    int m_phase, m_k, m_rc, m_cc, m_beats, m_drain;
    logic [N*WDATA-1:0] hist_a [$];
    logic [N*WDATA-1:0] hist_b [$];

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(N), .WDATA(WDATA), .CFG_WIDTH(CFG_WIDTH), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .row_cfg_in(row_cfg_in), .col_cfg_in(col_cfg_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .west_out(west_out), .north_out(north_out), .busy(busy), .done(done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WDATA-1:0] lane_exp(input bit is_a, input int r);
        int idx;
        logic [N*WDATA-1:0] v;
        if (r > (is_a ? m_rc : m_cc)) return '0;
        idx = (is_a ? hist_a.size() : hist_b.size()) - r;
        if (idx < 0) return '0;
        v = is_a ? hist_a[idx] : hist_b[idx];
        return v[(r-1)*WDATA +: WDATA];
    endfunction

    task automatic reset_model();
        m_phase = 0; m_k = 0; m_rc = 0; m_cc = 0; m_beats = 0; m_drain = 0;
        hist_a.delete();
        hist_b.delete();
    endtask

    task automatic model_edge();
        bit acc;
        logic [N*WDATA-1:0] pa, pb;
        acc = (m_phase == 1) && in_valid;
        pa  = '0;
        pb  = '0;
        if (acc) begin
            for (int r = 1; r <= N; r++) begin
                pa[(r-1)*WDATA +: WDATA] = in_a[r];
                pb[(r-1)*WDATA +: WDATA] = in_b[r];
            end
        end
        hist_a.push_back(pa);
        hist_b.push_back(pb);
        if (hist_a.size() > N) begin
            hist_a.delete(0);
            hist_b.delete(0);
        end
        case (m_phase)
            0: if (start) begin
                m_k     = int'(k_len);
                m_rc    = (int'(row_cfg_in) > N) ? N : int'(row_cfg_in);
                m_cc    = (int'(col_cfg_in) > N) ? N : int'(col_cfg_in);
                m_beats = 0;
                m_phase = (m_k == 0) ? 3 : 1;
            end
            1: if (acc) begin
                m_beats++;
                if (m_beats == m_k) begin
                    m_phase = 2;
                    m_drain = 2 * N - 1;
                end
            end
            2: begin
                m_drain--;
                if (m_drain == 0) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_outputs();
        check_val("in_ready", in_ready, m_phase == 1);
        check_val("busy", busy, m_phase != 0);
        check_val("done", done, m_phase == 3);
        for (int r = 1; r <= N; r++) begin
            check_val($sformatf("west%0d", r), west_out[r], lane_exp(1'b1, r));
            check_val($sformatf("north%0d", r), north_out[r], lane_exp(1'b0, r));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_data(input int mode);
        for (int r = 1; r <= N; r++) begin
            case (mode)
                1: begin
                    in_a[r] = WDATA'(4 * m_beats + r);
                    in_b[r] = WDATA'(4 * m_beats + r);
                end
                2: begin
                    in_a[r] = WDATA'(15);
                    in_b[r] = WDATA'(15);
                end
                default: begin
                    in_a[r] = WDATA'($urandom);
                    in_b[r] = WDATA'($urandom);
                end
            endcase
        end
    endtask

    task automatic job(input int k, input int rc, input int cc, input int pct, input int mode,
                       input int stall_at, input int exp_len, input bit inject);
        int edges, done_edge, lcyc, guard;
        start      = 1'b1;
        k_len      = KW'(k);
        row_cfg_in = CFG_WIDTH'(rc);
        col_cfg_in = CFG_WIDTH'(cc);
        in_valid   = 1'b0;
        set_data(mode);
        step();
        start      = 1'b0;
        edges      = 0;
        done_edge  = (done === 1'b1) ? 0 : -1;
        lcyc       = 0;
        guard      = 0;
        k_len      = KW'($urandom);
        row_cfg_in = CFG_WIDTH'($urandom);
        col_cfg_in = CFG_WIDTH'($urandom);
        while (m_phase != 0 && guard < 400) begin
            if (m_phase == 1) begin
                in_valid = (lcyc == stall_at) ? 1'b0 : ($urandom_range(99, 0) < pct);
                lcyc++;
            end else begin
                in_valid = 1'($urandom);
            end
            set_data(mode);
            start = inject ? 1'($urandom) : 1'b0;
            step();
            edges++;
            guard++;
            if (done === 1'b1 && done_edge < 0) done_edge = edges;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (guard >= 400) check_val("job_timeout", 32'd1, 32'd0);
        if (exp_len >= 0) check_val("job_len", done_edge, exp_len);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        k_len      = '0;
        row_cfg_in = '0;
        col_cfg_in = '0;
        for (int r = 1; r <= N; r++) begin
            in_a[r] = '0;
            in_b[r] = '0;
        end
        reset_model();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        job(3, 4, 4, 100, 1, -1, 3 + 2*N - 1, 1'b0);      // skew, no stall
        job(2, 4, 4, 100, 1, 1, 2 + 2*N - 1 + 1, 1'b0);   // one stall between beats
        job(4, 2, 3, 100, 2, -1, 4 + 2*N - 1, 1'b0);      // masking
        job(0, 4, 4, 100, 0, -1, 0, 1'b0);                // zero length
        job(5, 4, 4, 60, 0, -1, -1, 1'b1);                // start pulses while busy
        job(3, 7, 7, 100, 0, -1, 3 + 2*N - 1, 1'b0);      // clamp

        // Asynchronous reset in the middle of LOAD with live skew contents.
        start      = 1'b1;
        k_len      = KW'(5);
        row_cfg_in = CFG_WIDTH'(4);
        col_cfg_in = CFG_WIDTH'(4);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            set_data(0);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", busy, 32'd0);
        check_val("rst_ready", in_ready, 32'd0);
        for (int r = 1; r <= N; r++) begin
            check_val($sformatf("rst_west%0d", r), west_out[r], 32'd0);
            check_val($sformatf("rst_north%0d", r), north_out[r], 32'd0);
        end
        reset_model();
        check_outputs();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        job(1, 4, 4, 100, 0, -1, 1 + 2*N - 1, 1'b0);

        for (int j = 0; j < 30; j++) begin
            job($urandom_range(8, 0), $urandom_range(7, 0), $urandom_range(7, 0),
                $urandom_range(100, 30), 0, -1, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
